block_sprite_loader: RTL and testbench

//   Write-side engine for the block sprite RAM: accepts a packed byte stream (UART/ROM

---
 rtl/block_pkg.sv | 16 +
 rtl/block_sprite_loader_if.sv | 12 +
 rtl/block_sprite_loader.sv | 147 ++++++++++++++
 tb/tb_block_sprite_loader.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/block_pkg.sv
// Types and constants shared by the sprite loader and the block renderer's sprite RAM.
package block_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BYTE,
        UNPACK,
        DONE
    } state_t;

    localparam int PIX_PER_BYTE = 4;
    localparam int PIX_BITS     = 2;
    localparam int SPRITE_ADDR  = 10;
    localparam int BYTE_BITS    = PIX_PER_BYTE * PIX_BITS;

endpackage

// File: rtl/block_sprite_loader_if.sv
// Packed-pixel byte stream with valid/ready handshake, from the host byte bridge.
interface block_sprite_loader_if;
    import block_pkg::*;

    logic [BYTE_BITS-1:0] s_data;
    logic                 s_valid;
    logic                 s_ready;

    modport master (output s_data, output s_valid, input  s_ready);
    modport slave  (input  s_data, input  s_valid, output s_ready);

endinterface

// File: rtl/block_sprite_loader.sv
// Sprite RAM write engine: takes one packed byte at a time and writes its four
// 2-bit palette codes to consecutive addresses, one full image per start.
module block_sprite_loader
    import block_pkg::*;
#(
    parameter int ADDR    = SPRITE_ADDR,
    parameter int TIMEOUT = 100000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    block_sprite_loader_if.slave  s,
    output logic                  we,
    output logic [ADDR-1:0]       addr_w,
    output logic [PIX_BITS-1:0]   pixel_in,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int PW = $clog2(PIX_PER_BYTE);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [PW-1:0] PIX_LAST = PW'(PIX_PER_BYTE - 1);

    state_t               state_q, state_d;
    logic [BYTE_BITS-1:0] byte_q, byte_d;
    logic [PW-1:0]        pix_q, pix_d;
    // One extra bit so the wrap after the last pixel reads as completion.
    logic [ADDR:0]        cnt_q, cnt_d;
    logic [TW-1:0]        tmo_q, tmo_d;
    logic                 s_ready_q, s_ready_d;
    logic                 we_q, we_d;
    logic [ADDR-1:0]      addr_w_q, addr_w_d;
    logic [PIX_BITS-1:0]  pixel_in_q, pixel_in_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            byte_q     <= '0;
            pix_q      <= '0;
            cnt_q      <= '0;
            tmo_q      <= '0;
            s_ready_q  <= 1'b0;
            we_q       <= 1'b0;
            addr_w_q   <= '0;
            pixel_in_q <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_q     <= byte_d;
            pix_q      <= pix_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            s_ready_q  <= s_ready_d;
            we_q       <= we_d;
            addr_w_q   <= addr_w_d;
            pixel_in_q <= pixel_in_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_d     = byte_q;
        pix_d      = pix_q;
        cnt_d      = cnt_q;
        tmo_d      = tmo_q;
        we_d       = 1'b0;
        addr_w_d   = addr_w_q;
        pixel_in_d = pixel_in_q;
        done_d     = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = WAIT_BYTE;
                    cnt_d   = '0;
                    tmo_d   = '0;
                end
            end
            WAIT_BYTE: begin
                // The first pixel goes out on the handshake edge; the rest stay in the shifter.
                if (s.s_valid && s_ready_q) begin
                    byte_d     = s.s_data >> PIX_BITS;
                    pixel_in_d = s.s_data[PIX_BITS-1:0];
                    pix_d      = '0;
                    tmo_d      = '0;
                    we_d       = 1'b1;
                    addr_w_d   = cnt_q[ADDR-1:0];
                    cnt_d      = cnt_q + 1'b1;
                    state_d    = UNPACK;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            UNPACK: begin
                if (pix_q != PIX_LAST) begin
                    pixel_in_d = byte_q[PIX_BITS-1:0];
                    byte_d     = byte_q >> PIX_BITS;
                    pix_d      = pix_q + 1'b1;
                    we_d       = 1'b1;
                    addr_w_d   = cnt_q[ADDR-1:0];
                    cnt_d      = cnt_q + 1'b1;
                end else if (cnt_q[ADDR]) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = WAIT_BYTE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
            we_d    = 1'b0;
            done_d  = 1'b0;
            err_d   = 1'b0;
        end

        s_ready_d = (state_d == WAIT_BYTE);
    end

    assign s.s_ready = s_ready_q;
    assign we        = we_q;
    assign addr_w    = addr_w_q;
    assign pixel_in  = pixel_in_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_block_sprite_loader.sv
// Self-checking bench for block_sprite_loader: scoreboard of expected RAM writes plus a
// table of byte vectors and hand-written sequences for abort, timeout and reset.
module tb_block_sprite_loader;

    localparam int ADDR = 10;
    localparam int NPIX = 1 << ADDR;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b1;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic            we;
    logic [ADDR-1:0] addr_w;
    logic [1:0]      pixel_in;
    logic            busy;
    logic            done;
    logic            err;

    block_sprite_loader_if bus();

    always #5 clk = ~clk;

    block_sprite_loader #(.ADDR(ADDR), .TIMEOUT(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .s        (bus),
        .we       (we),
        .addr_w   (addr_w),
        .pixel_in (pixel_in),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    typedef struct {
        logic [ADDR-1:0] addr;
        logic [1:0]      pix;
    } wr_t;

    typedef struct {
        logic [7:0]      data;
        int              stall;
        logic [3:0][1:0] pix;
    } vec_t;

    wr_t             sb[$];
    vec_t            tbl[6];
    int              n_vec    = 0;
    int              n_fail   = 0;
    int              wr_cnt   = 0;
    int              done_cnt = 0;
    int              err_cnt  = 0;
    int              rdy_cnt  = 0;
    int              exp_addr = 0;
    logic            prev_we  = 1'b0;
    logic [ADDR-1:0] prev_addr = '0;
    logic [ADDR-1:0] last_addr = '0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Advance one clock and observe the write port just after the edge.
    task automatic tick();
        wr_t e;
        @(posedge clk);
        #1;
        if (bus.s_ready) rdy_cnt++;
        if (we) begin
            wr_cnt++;
            last_addr = addr_w;
            if (sb.size() == 0) begin
                check("unexpected_write", int'(addr_w), -1);
            end else begin
                e = sb.pop_front();
                check("wr_addr", int'(addr_w), int'(e.addr));
                check("wr_pix", int'(pixel_in), int'(e.pix));
            end
        end
        if (done) begin
            done_cnt++;
            check("done_after_last", int'({prev_we, prev_addr}), int'({1'b1, ADDR'(NPIX - 1)}));
        end
        if (err) err_cnt++;
        prev_we   = we;
        prev_addr = addr_w;
    endtask

    task automatic push_exp(input logic [3:0][1:0] pix);
        wr_t e;
        for (int k = 0; k < 4; k++) begin
            e.addr = ADDR'(exp_addr);
            e.pix  = pix[k];
            sb.push_back(e);
            exp_addr++;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int stall, input logic [3:0][1:0] pix);
        repeat (stall) tick();
        if (stall >= 5) check("ready_held", int'(bus.s_ready), 1);
        bus.s_valid = 1'b1;
        bus.s_data  = b;
        for (int n = 0; n < 40; n++) begin
            if (bus.s_ready) begin
                push_exp(pix);
                tick();
                bus.s_valid = 1'b0;
                return;
            end
            tick();
        end
        check("handshake_timeout", 0, 1);
        bus.s_valid = 1'b0;
    endtask

    task automatic clear_counts();
        wr_cnt   = 0;
        done_cnt = 0;
        err_cnt  = 0;
        exp_addr = 0;
        sb.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int n;
        tbl[0] = '{data: 8'hE4, stall: 7, pix: {2'd3, 2'd2, 2'd1, 2'd0}};
        tbl[1] = '{data: 8'h1B, stall: 7, pix: {2'd0, 2'd1, 2'd2, 2'd3}};
        tbl[2] = '{data: 8'h00, stall: 0, pix: {2'd0, 2'd0, 2'd0, 2'd0}};
        tbl[3] = '{data: 8'hFF, stall: 7, pix: {2'd3, 2'd3, 2'd3, 2'd3}};
        tbl[4] = '{data: 8'hA5, stall: 3, pix: {2'd2, 2'd2, 2'd1, 2'd1}};
        tbl[5] = '{data: 8'h3C, stall: 7, pix: {2'd0, 2'd3, 2'd3, 2'd0}};

        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check("rst_s_ready", int'(bus.s_ready), 0);
        check("rst_we", int'(we), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        check("rst_addr_w", int'(addr_w), 0);
        check("rst_pixel_in", int'(pixel_in), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Full image, back-to-back bytes, with a start pulse while busy
        clear_counts();
        pulse_start();
        for (int i = 0; i < NPIX / 4; i++) begin
            send_byte(8'hE4, 0, {2'd3, 2'd2, 2'd1, 2'd0});
            if (i == 128) pulse_start();
        end
        n = 0;
        while (done_cnt == 0 && n < 20) begin
            tick();
            n++;
        end
        tick();
        check("full_writes", wr_cnt, NPIX);
        check("full_done_cnt", done_cnt, 1);
        check("full_err_cnt", err_cnt, 0);
        check("full_busy_after", int'(busy), 0);
        check("full_sb_empty", sb.size(), 0);

        // Extra byte offered after done
        rdy_cnt     = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = 8'hFF;
        repeat (10) tick();
        bus.s_valid = 1'b0;
        check("extra_ready", rdy_cnt, 0);
        check("extra_writes", wr_cnt, NPIX);
        check("extra_busy", int'(busy), 0);

        // Table vectors with backpressure gaps
        clear_counts();
        pulse_start();
        for (int i = 0; i < 6; i++) send_byte(tbl[i].data, tbl[i].stall, tbl[i].pix);
        repeat (4) tick();
        check("tbl_writes", wr_cnt, 24);
        check("tbl_err_cnt", err_cnt, 0);
        check("tbl_sb_empty", sb.size(), 0);
        check("tbl_busy", int'(busy), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("tbl_abort_busy", int'(busy), 0);
        check("tbl_abort_ready", int'(bus.s_ready), 0);
        check("tbl_abort_done", done_cnt, 0);

        // Byte timeout after three bytes
        clear_counts();
        pulse_start();
        for (int i = 0; i < 3; i++) send_byte(8'h1B, 0, {2'd0, 2'd1, 2'd2, 2'd3});
        n = 0;
        while (err_cnt == 0 && n < 40) begin
            tick();
            n++;
        end
        check("tmo_latency", n, 20);
        check("tmo_err_cnt", err_cnt, 1);
        repeat (20) tick();
        check("tmo_err_once", err_cnt, 1);
        check("tmo_writes", wr_cnt, 12);
        check("tmo_done_cnt", done_cnt, 0);
        check("tmo_busy", int'(busy), 0);
        check("tmo_sb_empty", sb.size(), 0);

        // Abort during the second pixel of byte 5, then restart
        clear_counts();
        pulse_start();
        for (int i = 0; i < 4; i++) send_byte(8'hE4, 0, {2'd3, 2'd2, 2'd1, 2'd0});
        send_byte(8'h1B, 0, {2'd0, 2'd1, 2'd2, 2'd3});
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_we", int'(we), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_ready", int'(bus.s_ready), 0);
        check("abort_last_addr", int'(last_addr), 17);
        check("abort_writes", wr_cnt, 18);
        check("abort_pending", sb.size(), 2);
        sb.delete();
        repeat (3) tick();
        check("abort_quiet", wr_cnt, 18);
        check("abort_done_err", done_cnt + err_cnt, 0);
        exp_addr = 0;
        pulse_start();
        send_byte(8'hA5, 0, {2'd2, 2'd2, 2'd1, 2'd1});
        check("restart_addr", int'(last_addr), 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        sb.delete();

        // Abort and start together in IDLE
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_busy", int'(busy), 0);
        check("start_abort_ready", int'(bus.s_ready), 0);

        // Asynchronous reset in the middle of unpacking
        clear_counts();
        pulse_start();
        send_byte(8'hE4, 0, {2'd3, 2'd2, 2'd1, 2'd0});
        send_byte(8'h1B, 0, {2'd0, 2'd1, 2'd2, 2'd3});
        check("pre_rst_we", int'(we), 1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_we", int'(we), 0);
        check("mid_rst_ready", int'(bus.s_ready), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_addr_w", int'(addr_w), 0);
        sb.delete();
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("post_rst_busy", int'(busy), 0);
        check("post_rst_writes", wr_cnt, 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
